pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage RV32 pipeline. It tracks the destination and source registers of in-flight instructions in its own shadow slots for the E, M and W stages. From these it drives the stall, flush and forwarding controls of the fetch, decode and execute pipeline registers. It also freezes the whole pipeline while data memory is busy and keeps saturating event counters for bring-up.

## Interface
- CNT_W, 16, width of each saturating event counter
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- Rs1D  in  5  rs1 field of the instruction in D (InstrD[19:15])
- Rs2D  in  5  rs2 field of the instruction in D (InstrD[24:20])
- RdD  in  5  rd field of the instruction in D (InstrD[11:7])
- RegWriteD  in  1  instruction in D writes the register file
- ResultSrcD  in  1  instruction in D is a load (1 = result from memory)
- PCSrcE  in  1  branch in E resolved taken
- MemBusyM  in  1  data memory not ready; freeze the pipeline
- StallF, StallD  out  1 each  hold the PC register / the IF-ID register
- StallE, StallM  out  1 each  hold the ID-EX register / the EX-MEM register
- FlushD, FlushE  out  1 each  clear the IF-ID register / the ID-EX register to a bubble
- ForwardAE, ForwardBE  out  2 each  ALU operand A/B source: 00 register file, 01 ResultW, 10 ALUResultM
- StallCnt, FlushCnt, BusyCnt  out  CNT_W each  load-use stall cycles, taken-branch flushes, memory-busy cycles

## Operation
- Shadow slots:
  - E = {valid, rd, regwrite, load, rs1, rs2}
  - M = {valid, rd, regwrite}
  - W = {valid, rd, regwrite}
  - All three are registered.
- Load-use hazard, lu: E.valid & E.load & E.rd≠0 & (E.rd==Rs1D | E.rd==Rs2D).
- Control decode, priority top-down, evaluated combinationally each cycle:
  1. rst high: every control output is 0.
  2. MemBusyM: StallF=StallD=StallE=StallM=1, all flushes 0. All slots hold.
  3. PCSrcE: FlushD=1, FlushE=1, no stalls. lu is ignored, because the instruction in D is being discarded.
  4. lu: StallF=1, StallD=1, FlushE=1.
  5. Otherwise all controls are 0.
- Slot update at the clock edge when not frozen:
  - W ← M and M ← E.
  - E ← bubble (valid=0) if FlushE.
  - Otherwise E ← {1, RdD, RegWriteD, ResultSrcD, Rs1D, Rs2D}.
- Forwarding (ForwardAE shown; ForwardBE is identical using E.rs2):
  - 10 if M.valid & M.regwrite & M.rd≠0 & M.rd==E.rs1.
  - else 01 if W.valid & W.regwrite & W.rd≠0 & W.rd==E.rs1.
  - else 00.
  - M has priority over W.
  - Forward selects stay valid during MemBusyM freeze; they are computed from the held slots.
- x0 never causes a hazard or a forward.
- Counters saturate at all-ones; they do not wrap.
  - StallCnt +1 per cycle with lu selected (rule 4).
  - FlushCnt +1 per cycle with rule 3.
  - BusyCnt +1 per MemBusyM cycle.
  - Counters do not increment while rst is high.
- A bubble in D (IF-ID cleared: RegWriteD=0, ResultSrcD=0) enters E as valid but harmless. It is non-writing, so it can neither trigger lu nor be forwarded.

## Timing
- Reset (asynchronous, mid-operation included):
  - All slots valid=0, all counters 0, all outputs 0 the same cycle rst rises.
  - First valid E capture happens at the first rising edge after rst falls.
- Stall/flush/forward outputs are combinational from the slots and D-stage inputs, with zero latency. The pipeline registers sample them at the same edge.
- Load-use costs exactly 1 stall cycle:
  - Cycle n: lu=1.
  - Edge n: E becomes a bubble and the load moves to M.
  - Cycle n+1: lu=0 and the dependent instruction proceeds.
  - The load result reaches the dependent instruction by W-forward (01) one cycle later.
- Taken branch costs 2 bubbles: the D and E contents are squashed at the same edge.
- MemBusyM held for k cycles extends every stage by exactly k cycles. No slot changes and no instruction is lost or duplicated.
- Simultaneous events:
  - MemBusyM with PCSrcE: the freeze wins and the flush is applied on the first non-busy cycle, with PCSrcE still held by the frozen E stage.
  - PCSrcE with lu: flush only; StallCnt is not incremented.

## Test plan
- Reset mid-stream: assert rst while lu is active -> StallF/StallD/FlushE drop to 0 immediately, StallCnt=0; after release, ADD x1 enters E with valid=1 at the first edge.
- Forwarding:
  - ADD x5 in M, ADD x5 in W, SUB uses x5 as rs1 and rs2 -> ForwardAE=ForwardBE=10 (M priority).
  - With M rd=0 writing -> 01.
  - Unrelated rd -> 00.
- Load-use: LW x3 then ADD x4,x3,x2 -> exactly one cycle StallF=StallD=FlushE=1, then ForwardAE=01 for the ADD; StallCnt=1.
- Taken branch: PCSrcE=1 for one cycle with LW x3 in E and a dependent instruction in D -> FlushD=FlushE=1, StallF=StallD=0, FlushCnt=1, StallCnt=0.
- Memory busy: MemBusyM high 3 cycles with ADD x6 in M and a user in E -> all four stalls 1, ForwardAE held at 10 for all 3 cycles, BusyCnt=3, no slot change.
- Saturation: CNT_W=4, 20 consecutive load-use stalls -> StallCnt stops at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32 pipeline: load-use stall,
// taken-branch flush, memory-busy freeze, E-stage forwarding and event counters.
module pipe_hazard_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       RdD,
   input  logic             RegWriteD,
   input  logic             ResultSrcD,
   input  logic             PCSrcE,
   input  logic             MemBusyM,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt,
   output logic [CNT_W-1:0] BusyCnt
);

   // Shadow slots for the instructions in E, M and W.
   logic       e_valid_q, e_regwrite_q, e_load_q;
   logic [4:0] e_rd_q, e_rs1_q, e_rs2_q;
   logic       m_valid_q, m_regwrite_q;
   logic [4:0] m_rd_q;
   logic       w_valid_q, w_regwrite_q;
   logic [4:0] w_rd_q;

   logic lu;
   logic busy_sel, flush_sel, stall_sel;

   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic       mv,
      input logic       mw,
      input logic [4:0] mrd,
      input logic       wv,
      input logic       ww,
      input logic [4:0] wrd
   );
      if (mv && mw && (mrd != 5'd0) && (mrd == rs)) begin
         return 2'b10;
      end else if (wv && ww && (wrd != 5'd0) && (wrd == rs)) begin
         return 2'b01;
      end
      return 2'b00;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign lu = e_valid_q && e_load_q && (e_rd_q != 5'd0) &&
               ((e_rd_q == Rs1D) || (e_rd_q == Rs2D));

   // Priority: reset, memory freeze, taken branch, load-use.
   always_comb begin
      busy_sel  = 1'b0;
      flush_sel = 1'b0;
      stall_sel = 1'b0;
      if (!rst) begin
         if (MemBusyM) begin
            busy_sel = 1'b1;
         end else if (PCSrcE) begin
            flush_sel = 1'b1;
         end else if (lu) begin
            stall_sel = 1'b1;
         end
      end
   end

   always_comb begin
      StallF    = busy_sel | stall_sel;
      StallD    = busy_sel | stall_sel;
      StallE    = busy_sel;
      StallM    = busy_sel;
      FlushD    = flush_sel;
      FlushE    = flush_sel | stall_sel;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      if (!rst) begin
         ForwardAE = fwd_sel(e_rs1_q, m_valid_q, m_regwrite_q, m_rd_q,
                             w_valid_q, w_regwrite_q, w_rd_q);
         ForwardBE = fwd_sel(e_rs2_q, m_valid_q, m_regwrite_q, m_rd_q,
                             w_valid_q, w_regwrite_q, w_rd_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_valid_q    <= 1'b0;
         e_regwrite_q <= 1'b0;
         e_load_q     <= 1'b0;
         e_rd_q       <= 5'd0;
         e_rs1_q      <= 5'd0;
         e_rs2_q      <= 5'd0;
         m_valid_q    <= 1'b0;
         m_regwrite_q <= 1'b0;
         m_rd_q       <= 5'd0;
         w_valid_q    <= 1'b0;
         w_regwrite_q <= 1'b0;
         w_rd_q       <= 5'd0;
      end else if (!MemBusyM) begin
         w_valid_q    <= m_valid_q;
         w_regwrite_q <= m_regwrite_q;
         w_rd_q       <= m_rd_q;
         m_valid_q    <= e_valid_q;
         m_regwrite_q <= e_regwrite_q;
         m_rd_q       <= e_rd_q;
         if (FlushE) begin
            // Bubble fields are cleared so a stale rs cannot match a forward.
            e_valid_q    <= 1'b0;
            e_regwrite_q <= 1'b0;
            e_load_q     <= 1'b0;
            e_rd_q       <= 5'd0;
            e_rs1_q      <= 5'd0;
            e_rs2_q      <= 5'd0;
         end else begin
            e_valid_q    <= 1'b1;
            e_regwrite_q <= RegWriteD;
            e_load_q     <= ResultSrcD;
            e_rd_q       <= RdD;
            e_rs1_q      <= Rs1D;
            e_rs2_q      <= Rs2D;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         StallCnt <= '0;
         FlushCnt <= '0;
         BusyCnt  <= '0;
      end else begin
         if (stall_sel) StallCnt <= sat_inc(StallCnt);
         if (flush_sel) FlushCnt <= sat_inc(FlushCnt);
         if (busy_sel)  BusyCnt  <= sat_inc(BusyCnt);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed D-stage vectors push expected
// controls/counters; a monitor pops and compares once per cycle (or on reset).
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] Rs1D = '0, Rs2D = '0, RdD = '0;
   logic       RegWriteD = 1'b0, ResultSrcD = 1'b0, PCSrcE = 1'b0, MemBusyM = 1'b0;

   logic        StallF, StallD, StallE, StallM, FlushD, FlushE;
   logic [1:0]  ForwardAE, ForwardBE;
   logic [15:0] StallCnt, FlushCnt, BusyCnt;

   logic        s4_StallF, s4_StallD, s4_StallE, s4_StallM, s4_FlushD, s4_FlushE;
   logic [1:0]  s4_ForwardAE, s4_ForwardBE;
   logic [3:0]  s4_StallCnt, s4_FlushCnt, s4_BusyCnt;

   logic [9:0]  ctl;
   assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE};

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
      .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .PCSrcE(PCSrcE), .MemBusyM(MemBusyM),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallCnt(StallCnt), .FlushCnt(FlushCnt), .BusyCnt(BusyCnt)
   );

   pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
      .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .PCSrcE(PCSrcE), .MemBusyM(MemBusyM),
      .StallF(s4_StallF), .StallD(s4_StallD), .StallE(s4_StallE), .StallM(s4_StallM),
      .FlushD(s4_FlushD), .FlushE(s4_FlushE), .ForwardAE(s4_ForwardAE),
      .ForwardBE(s4_ForwardBE), .StallCnt(s4_StallCnt), .FlushCnt(s4_FlushCnt),
      .BusyCnt(s4_BusyCnt)
   );

   // ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE}
   localparam logic [9:0] C_LU   = 10'h310;
   localparam logic [9:0] C_FL   = 10'h030;
   localparam logic [9:0] C_BUSY = 10'h3C0;
   localparam logic [9:0] FA10   = 10'h008;
   localparam logic [9:0] FA01   = 10'h004;
   localparam logic [9:0] FB10   = 10'h002;
   localparam logic [9:0] FB01   = 10'h001;

   typedef struct {
      string      name;
      logic [9:0] ctl;
      int         sc;
      int         fc;
      int         bc;
      int         sc4;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, req);
   endtask

   always begin
      @(negedge clk or posedge rst);
      #1;
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         check({mon_e.name, ".ctl"},   32'(ctl),      32'(mon_e.ctl));
         check({mon_e.name, ".stall"}, 32'(StallCnt), mon_e.sc);
         check({mon_e.name, ".flush"}, 32'(FlushCnt), mon_e.fc);
         check({mon_e.name, ".busy"},  32'(BusyCnt),  mon_e.bc);
         if (mon_e.sc4 >= 0) check({mon_e.name, ".stall4"}, 32'(s4_StallCnt), mon_e.sc4);
      end
   end

   task automatic step(input string nm, input logic r,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic ld, input logic pc, input logic mb,
                       input logic [9:0] c, input int sc, input int fc, input int bc,
                       input int sc4 = -1);
      @(posedge clk);
      #1;
      rst        = r;
      Rs1D       = rs1;
      Rs2D       = rs2;
      RdD        = rd;
      RegWriteD  = rw;
      ResultSrcD = ld;
      PCSrcE     = pc;
      MemBusyM   = mb;
      sb.push_back('{nm, c, sc, fc, bc, sc4});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int sc;
      // Forwarding: ADD x5, ADD x5, SUB x7,x5,x5, ADD x5, ADD x0, SUB x6,x5,x5, ...
      step("reset",      1, 1, 2, 5, 1, 0, 0, 0, 10'h000,   0, 0, 0);
      step("empty",      0, 1, 2, 5, 1, 0, 0, 0, 10'h000,   0, 0, 0);
      step("i2",         0, 1, 2, 5, 1, 0, 0, 0, 10'h000,   0, 0, 0);
      step("i3",         0, 5, 5, 7, 1, 0, 0, 0, 10'h000,   0, 0, 0);
      step("fwd_m_prio", 0, 1, 2, 5, 1, 0, 0, 0, FA10|FB10, 0, 0, 0);
      step("i5",         0, 1, 2, 0, 1, 0, 0, 0, 10'h000,   0, 0, 0);
      step("i6",         0, 5, 5, 6, 1, 0, 0, 0, 10'h000,   0, 0, 0);
      step("fwd_w_mx0",  0, 1, 2, 9, 1, 0, 0, 0, FA01|FB01, 0, 0, 0);
      step("i8",         0, 8, 8, 10, 1, 0, 0, 0, 10'h000,  0, 0, 0);
      step("fwd_none",   0, 0, 0, 0, 0, 0, 0, 0, 10'h000,   0, 0, 0);
      // Load-use: LW x3 then ADD x4,x3,x2
      step("lw",         0, 2, 0, 3, 1, 1, 0, 0, 10'h000,   0, 0, 0);
      step("lu_stall",   0, 3, 2, 4, 1, 0, 0, 0, C_LU,      0, 0, 0);
      step("lu_release", 0, 3, 2, 4, 1, 0, 0, 0, 10'h000,   1, 0, 0);
      step("lu_wfwd",    0, 0, 0, 0, 0, 0, 0, 0, FA01,      1, 0, 0);
      // Taken branch with LW x3 in E and a dependent in D
      step("br_lw",      0, 2, 0, 3, 1, 1, 0, 0, 10'h000,   1, 0, 0);
      step("br_flush",   0, 3, 2, 4, 1, 0, 1, 0, C_FL,      1, 0, 0);
      step("br_after",   0, 0, 0, 0, 0, 0, 0, 0, 10'h000,   1, 1, 0);
      // Memory busy 3 cycles with ADD x6 in M, SUB using x6 in E
      step("add6",       0, 1, 2, 6, 1, 0, 0, 0, 10'h000,   1, 1, 0);
      step("user6",      0, 6, 6, 11, 1, 0, 0, 0, 10'h000,  1, 1, 0);
      step("busy1",      0, 0, 0, 0, 0, 0, 0, 1, C_BUSY|FA10|FB10, 1, 1, 0);
      step("busy2",      0, 0, 0, 0, 0, 0, 0, 1, C_BUSY|FA10|FB10, 1, 1, 1);
      step("busy3",      0, 0, 0, 0, 0, 0, 0, 1, C_BUSY|FA10|FB10, 1, 1, 2);
      step("busy_done",  0, 0, 0, 0, 0, 0, 0, 0, FA10|FB10, 1, 1, 3);
      step("post_busy",  0, 0, 0, 0, 0, 0, 0, 0, 10'h000,   1, 1, 3);
      // Busy together with taken branch: freeze first, flush next cycle
      step("busy_br",    0, 0, 0, 0, 0, 0, 1, 1, C_BUSY,    1, 1, 3);
      step("br_unfrz",   0, 0, 0, 0, 0, 0, 1, 0, C_FL,      1, 1, 4);
      step("idle",       0, 0, 0, 0, 0, 0, 0, 0, 10'h000,   1, 2, 4);
      // Reset while load-use is active
      step("lw2",        0, 2, 0, 3, 1, 1, 0, 0, 10'h000,   1, 2, 4);
      step("lu_pre_rst", 0, 3, 2, 4, 1, 0, 0, 0, C_LU,      1, 2, 4);
      @(negedge clk);
      #2;
      sb.push_back('{"rst_mid", 10'h000, 0, 0, 0, 0});
      rst = 1'b1;
      step("rel_add1",   0, 2, 3, 1, 1, 0, 0, 0, 10'h000,   0, 0, 0);
      step("add1_use",   0, 1, 1, 12, 1, 0, 0, 0, 10'h000,  0, 0, 0);
      step("add1_fwd",   0, 0, 0, 0, 0, 0, 0, 0, FA10|FB10, 0, 0, 0);
      // Saturation: LW x3,0(x3) repeated -> a load-use stall every other cycle
      for (int k = 0; k <= 40; k++) begin
         if (k % 2 == 1) begin
            sc = (k - 1) / 2;
            step($sformatf("sat%0d", k), 0, 3, 0, 3, 1, 1, 0, 0,
                 (k == 1) ? C_LU : (C_LU | FA01), sc, 0, 0, (sc > 15) ? 15 : sc);
         end else begin
            sc = k / 2;
            step($sformatf("sat%0d", k), 0, 3, 0, 3, 1, 1, 0, 0,
                 10'h000, sc, 0, 0, (sc > 15) ? 15 : sc);
         end
      end
      step("sat_end",    0, 0, 0, 0, 0, 0, 0, 0, FA01,      20, 0, 0, 15);
      @(negedge clk);
      @(negedge clk);
      #3;
      check("sb_drain", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
